moesi_snoop_interconnect: RTL
=============================

// Module: moesi_snoop_interconnect
// PURPOSE
//  NUM_CORES-way coherency interconnect between the per-core cache controllers and shared_memory.
//  Round-robin arbitration; snoop broadcast; snoop-response collection; cache-to-cache or memory
//  data sourcing; memory writeback. Routes one response to the requester. One transaction in flight.
// PARAMETERS
//  NUM_CORES   4    requesting cache controllers (>=2)
//  ADDR_WIDTH  64   line address width
//  DATA_WIDTH  512  cache line width in bits
//  ID_W        $clog2(NUM_CORES)  core-id width (localparam, not overridable)
// PORTS
//  clk             in   1               clock, single domain
//  rst_n           in   1               synchronous reset, active-low
//  req_valid       in   NUM_CORES       per-core request; held with type/addr/wdata until req_ready
//  req_type        in   NUM_CORES x2    00 WB, 01 BusRd, 10 BusRdX, 11 BusUpgr
//  req_addr        in   NUM_CORES xAW   line address
//  req_wdata       in   NUM_CORES xDW   writeback data; used for WB only
//  req_ready       out  NUM_CORES       one-hot, 1-cycle pulse: request accepted
//  resp_valid      out  NUM_CORES       one-hot, 1-cycle completion pulse to the requester
//  resp_data       out  DW              line data; 0 for WB and BusUpgr
//  resp_shared     out  1               BusRd only: another cache holds the line (fill S, not E)
//  snoop_valid     out  1               1-cycle snoop broadcast
//  snoop_type      out  2               latched req_type
//  snoop_addr      out  AW              latched req_addr
//  snoop_src       out  ID_W            requester id; caches ignore own snoop
//  snoop_hit       in   NUM_CORES       cache holds the line; sampled cycle after snoop_valid
//  snoop_supply    in   NUM_CORES       cache is in M/O and drives snoop_data; same cycle as hit
//  snoop_data      in   NUM_CORES xDW   supplied line
//  mem_req_valid   out  1               held until mem_req_ready
//  mem_req_write   out  1
//  mem_req_addr    out  AW
//  mem_req_wdata   out  DW
//  mem_req_ready   in   1
//  mem_resp_valid  in   1               read data valid, 1 cycle
//  mem_resp_rdata  in   DW
//  grant_id        out  ID_W            id of current or last granted core
//  busy            out  1               state != IDLE
//  proto_err       out  1               sticky protocol-error flag
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE; every valid/ready/flag output 0; data/addr outputs 0;
//   grant_id=0; RR pointer selects core 0 first; proto_err cleared. Mid-transaction reset
//   abandons the transaction. A later mem_resp_valid is ignored, as it is in every state but MEM_RD.
//  Arbitration (IDLE only): search starts at (last grant+1) mod NUM_CORES; first valid wins.
//   req_ready pulses that cycle. type/addr/wdata/id are latched; pointer updates.
//  FSM:
//   IDLE -grant-> WB ? MEM_WR : SNOOP
//   SNOOP (1 cyc): snoop_valid=1 -> COLLECT
//   COLLECT (1 cyc): mask snoop_hit/supply with ~(1<<src).
//    Upgr -> RESP. Supply present -> RESP, data = lowest-index supplier.
//    Otherwise -> MEM_RD. resp_shared <= |hit_masked when type=BusRd, else 0.
//   MEM_RD: mem_req_valid=1, write=0 until mem_req_ready. Then wait mem_resp_valid,
//    latch rdata -> RESP.
//   MEM_WR: mem_req_valid=1, write=1, wdata=latched, until mem_req_ready -> RESP.
//   RESP (1 cyc): resp_valid[src]=1 with resp_data/resp_shared -> IDLE.
//    A new grant is possible the following cycle.
//  Latency (grant at T0): C2C/Upgr resp at T3. Memory read: mem_req_valid first at T2+1.
//   Response is 1 cycle after mem_resp_valid. WB: resp 1 cycle after the mem handshake.
//  mem_req_valid may see mem_req_ready in its first cycle; handshake completes that cycle.
//  proto_err set, and held until reset, on any of:
//   >1 masked supplier (lowest index is still used); supply in an Upgr COLLECT;
//   mem_resp_valid outside MEM_RD wait after the first post-reset cycle.
//  Outputs are registered; no combinational path from any input to any output.
// TESTING
//  1 Reset/idle: hold rst_n=0 3 cycles mid-MEM_RD -> all outputs 0, busy=0.
//    A stale mem_resp_valid after release causes no resp_valid and no proto_err.
//  2 RR fairness: req_valid=4'b1111 held, each requester drops after its resp.
//    Grants go 0,1,2,3; re-request 0 and 2 -> grant 0 then 2.
//  3 C2C: core1 BusRd 0x40; snoop_hit=4'b1001, supply=4'b1000, data=D.
//    -> no mem_req_valid; resp_valid=4'b0010 at T3 with D; resp_shared=1.
//  4 Mem fill: core2 BusRdX 0x80, no hits; mem_req_ready after 2 cycles, rdata M 4 cycles later.
//    -> resp_valid[2] 1 cycle after mem_resp_valid, data M, resp_shared=0.
//  5 WB: core3 WB 0xC0 wdata W -> no snoop_valid.
//    mem_req_write=1, addr 0xC0, wdata W; resp_valid[3] after ready.
//  6 Errors: core0 BusRd, supply=4'b0110 -> data from core1, proto_err=1 and sticky.
//    Core0's own supply bit alone -> masked, memory read taken.

Source files
------------

// File: rtl/moesi_snoop_interconnect.sv
// MOESI snoop interconnect: round-robin arbitration, snoop broadcast,
// cache-to-cache or memory sourcing, writeback. One transaction in flight.
module moesi_snoop_interconnect #(
    parameter int NUM_CORES  = 4,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 512,
    localparam int ID_W      = $clog2(NUM_CORES)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_CORES-1:0]                 req_valid,
    input  logic [NUM_CORES-1:0][1:0]            req_type,
    input  logic [NUM_CORES-1:0][ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_CORES-1:0][DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_CORES-1:0]                 req_ready,
    output logic [NUM_CORES-1:0]                 resp_valid,
    output logic [DATA_WIDTH-1:0]                resp_data,
    output logic                                 resp_shared,
    output logic                                 snoop_valid,
    output logic [1:0]                           snoop_type,
    output logic [ADDR_WIDTH-1:0]                snoop_addr,
    output logic [ID_W-1:0]                      snoop_src,
    input  logic [NUM_CORES-1:0]                 snoop_hit,
    input  logic [NUM_CORES-1:0]                 snoop_supply,
    input  logic [NUM_CORES-1:0][DATA_WIDTH-1:0] snoop_data,
    output logic                                 mem_req_valid,
    output logic                                 mem_req_write,
    output logic [ADDR_WIDTH-1:0]                mem_req_addr,
    output logic [DATA_WIDTH-1:0]                mem_req_wdata,
    input  logic                                 mem_req_ready,
    input  logic                                 mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]                mem_resp_rdata,
    output logic [ID_W-1:0]                      grant_id,
    output logic                                 busy,
    output logic                                 proto_err
);

    localparam logic [1:0] T_WB   = 2'b00;
    localparam logic [1:0] T_RD   = 2'b01;
    localparam logic [1:0] T_UPGR = 2'b11;

    typedef enum logic [2:0] {
        IDLE, SNOOP, COLLECT, MEM_RD, MEM_RD_WAIT, MEM_WR, RESP
    } state_t;

    state_t                 state_q, state_d;
    logic [ID_W-1:0]        src_q, ptr_q, gnt_id, sup_id;
    logic [1:0]             type_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  wdata_q, resp_data_q;
    logic [NUM_CORES-1:0]   req_ready_q, src_mask, hit_m, sup_m;
    logic                   resp_shared_q, err_q, first_q;
    logic                   gnt_found, sup_any, sup_multi;

    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!gnt_found && req_valid[(int'(ptr_q) + i) % NUM_CORES]) begin
                gnt_found = 1'b1;
                gnt_id    = ID_W'((int'(ptr_q) + i) % NUM_CORES);
            end
        end
    end

    // Requester's own snoop response is never trusted.
    always_comb begin
        src_mask  = ~(NUM_CORES'(1) << src_q);
        hit_m     = snoop_hit & src_mask;
        sup_m     = snoop_supply & src_mask;
        sup_any   = |sup_m;
        sup_multi = |(sup_m & (sup_m - NUM_CORES'(1)));
        sup_id    = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (sup_m[i]) sup_id = ID_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:
                if (gnt_found)
                    state_d = (req_type[gnt_id] == T_WB) ? MEM_WR : SNOOP;
            SNOOP:   state_d = COLLECT;
            COLLECT:
                if (type_q == T_UPGR || sup_any) state_d = RESP;
                else                             state_d = MEM_RD;
            MEM_RD:      if (mem_req_ready)  state_d = MEM_RD_WAIT;
            MEM_RD_WAIT: if (mem_resp_valid) state_d = RESP;
            MEM_WR:      if (mem_req_ready)  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            src_q         <= '0;
            ptr_q         <= '0;
            type_q        <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            req_ready_q   <= '0;
            resp_data_q   <= '0;
            resp_shared_q <= 1'b0;
            err_q         <= 1'b0;
            first_q       <= 1'b0;
        end else begin
            first_q     <= 1'b1;
            req_ready_q <= '0;
            if (state_q == IDLE && gnt_found) begin
                src_q         <= gnt_id;
                ptr_q         <= ID_W'((int'(gnt_id) + 1) % NUM_CORES);
                type_q        <= req_type[gnt_id];
                addr_q        <= req_addr[gnt_id];
                wdata_q       <= req_wdata[gnt_id];
                req_ready_q   <= NUM_CORES'(1) << gnt_id;
                resp_data_q   <= '0;
                resp_shared_q <= 1'b0;
            end
            if (state_q == COLLECT) begin
                resp_shared_q <= (type_q == T_RD) && (|hit_m);
                if (type_q != T_UPGR && sup_any)
                    resp_data_q <= snoop_data[sup_id];
                if (sup_multi || (type_q == T_UPGR && sup_any))
                    err_q <= 1'b1;
            end
            if (state_q == MEM_RD_WAIT && mem_resp_valid)
                resp_data_q <= mem_resp_rdata;
            if (first_q && mem_resp_valid && state_q != MEM_RD_WAIT)
                err_q <= 1'b1;
        end
    end

    always_comb begin
        req_ready     = req_ready_q;
        resp_valid    = (state_q == RESP) ? (NUM_CORES'(1) << src_q) : '0;
        resp_data     = resp_data_q;
        resp_shared   = resp_shared_q;
        snoop_valid   = (state_q == SNOOP);
        snoop_type    = type_q;
        snoop_addr    = addr_q;
        snoop_src     = src_q;
        mem_req_valid = (state_q == MEM_RD) || (state_q == MEM_WR);
        mem_req_write = (state_q == MEM_WR);
        mem_req_addr  = addr_q;
        mem_req_wdata = wdata_q;
        grant_id      = src_q;
        busy          = (state_q != IDLE);
        proto_err     = err_q;
    end

endmodule
